// File: rtl/issue_queue_if.sv
// Fetch/pre-decode/issue signal bundle for issue_queue.
// slave is the queue side; master is the fetch, pre-decoder and decode side.
interface issue_queue_if #(
   parameter int DEPTH   = 16,
   parameter int ENTRY_W = 64
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic               flush;
   logic               push_en_1;
   logic [ENTRY_W-1:0] push_data_1;
   logic               push_en_2;
   logic [ENTRY_W-1:0] push_data_2;
   logic               queue_ready;
   logic [CW-1:0]      count;
   logic [ENTRY_W-1:0] hd_data_1;
   logic [ENTRY_W-1:0] hd_data_2;
   logic               hd_ok_1;
   logic               hd_ok_2;
   logic               hd1_is_jmp;
   logic               hd1_is_ls;
   logic [4:0]         hd1_w_reg_dst;
   logic               hd2_is_jmp;
   logic [4:0]         hd2_rs;
   logic [4:0]         hd2_rt;
   logic               issue_stall;
   logic               issue_valid_1;
   logic               issue_valid_2;
   logic [31:0]        issue_pc_1;
   logic [31:0]        issue_inst_1;
   logic [31:0]        issue_pc_2;
   logic [31:0]        issue_inst_2;

   // Push is fire-and-forget: a push is taken only if the whole group fits,
   // so fetch must gate push_en_* on queue_ready. issue_stall holds the slots.
   modport slave (
      input  flush, push_en_1, push_data_1, push_en_2, push_data_2,
      input  hd1_is_jmp, hd1_is_ls, hd1_w_reg_dst, hd2_is_jmp, hd2_rs, hd2_rt,
      input  issue_stall,
      output queue_ready, count, hd_data_1, hd_data_2, hd_ok_1, hd_ok_2,
      output issue_valid_1, issue_valid_2, issue_pc_1, issue_inst_1,
      output issue_pc_2, issue_inst_2
   );

   modport master (
      output flush, push_en_1, push_data_1, push_en_2, push_data_2,
      output hd1_is_jmp, hd1_is_ls, hd1_w_reg_dst, hd2_is_jmp, hd2_rs, hd2_rt,
      output issue_stall,
      input  queue_ready, count, hd_data_1, hd_data_2, hd_ok_1, hd_ok_2,
      input  issue_valid_1, issue_valid_2, issue_pc_1, issue_inst_1,
      input  issue_pc_2, issue_inst_2
   );
endinterface

// File: rtl/issue_queue.sv
// Dual-issue fetch-to-decode instruction queue with pairing rules and ID1 issue registers.
// Define ISSUE_DUAL_EN to allow two entries to issue per cycle; otherwise single issue.
module issue_queue #(
   parameter int DEPTH   = 16,
   parameter int ENTRY_W = 64
) (
   input logic          clk,
   input logic          resetn,
   issue_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
`ifdef ISSUE_DUAL_EN
   localparam logic [1:0] PAIR_POP = 2'd2;
`else
   localparam logic [1:0] PAIR_POP = 2'd1;
`endif

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_p1, wr_ptr_p1;
   logic [CW-1:0]      count_q, count_d;
   logic [CW-1:0]      free_after_pop;
   logic [1:0]         n_pop, n_push_req, n_push;
   logic               hd_ok_1, hd_ok_2, raw_hazard;

   logic               issue_valid_1_q, issue_valid_1_d;
   logic               issue_valid_2_q, issue_valid_2_d;
   logic [31:0]        issue_pc_1_q, issue_inst_1_q, issue_pc_2_q, issue_inst_2_q;

   assign rd_ptr_p1 = rd_ptr_q + PW'(1);
   assign wr_ptr_p1 = wr_ptr_q + PW'(1);
   assign hd_ok_1   = (count_q != '0);
   assign hd_ok_2   = (count_q >= CW'(2));

   assign raw_hazard = (bus.hd1_w_reg_dst != 5'd0) &&
                       ((bus.hd1_w_reg_dst == bus.hd2_rs) || (bus.hd1_w_reg_dst == bus.hd2_rt));

   // Pairing rules, highest priority first.
   always_comb begin
      n_pop = 2'd0;
      if (!hd_ok_1 || bus.issue_stall)       n_pop = 2'd0;
      else if (bus.hd1_is_jmp && !hd_ok_2)   n_pop = 2'd0;
      else if (bus.hd1_is_jmp)               n_pop = PAIR_POP;
      else if (!hd_ok_2)                     n_pop = 2'd1;
      else if (raw_hazard)                   n_pop = 2'd1;
      else if (bus.hd1_is_ls)                n_pop = 2'd1;
      else if (bus.hd2_is_jmp)               n_pop = 2'd1;
      else                                   n_pop = PAIR_POP;
   end

   // Space freed by this cycle's pop counts, so a full queue can pop 2 / push 2.
   always_comb begin
      n_push_req = 2'd0;
      if (bus.push_en_1) n_push_req = bus.push_en_2 ? 2'd2 : 2'd1;
      free_after_pop = CW'(DEPTH) - count_q + CW'(n_pop);
      n_push = (free_after_pop >= CW'(n_push_req)) ? n_push_req : 2'd0;
      count_d  = count_q + CW'(n_push) - CW'(n_pop);
      rd_ptr_d = rd_ptr_q + PW'(n_pop);
      wr_ptr_d = wr_ptr_q + PW'(n_push);
      issue_valid_1_d = (n_pop != 2'd0);
      issue_valid_2_d = (n_pop == 2'd2);
   end

   always_ff @(posedge clk) begin
      if (resetn && !bus.flush) begin
         if (n_push != 2'd0) mem_q[wr_ptr_q]  <= bus.push_data_1;
         if (n_push == 2'd2) mem_q[wr_ptr_p1] <= bus.push_data_2;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (bus.flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         issue_valid_1_q <= 1'b0;
         issue_valid_2_q <= 1'b0;
         issue_pc_1_q    <= '0;
         issue_inst_1_q  <= '0;
         issue_pc_2_q    <= '0;
         issue_inst_2_q  <= '0;
      end else if (bus.flush) begin
         issue_valid_1_q <= 1'b0;
         issue_valid_2_q <= 1'b0;
      end else if (!bus.issue_stall) begin
         issue_valid_1_q <= issue_valid_1_d;
         issue_valid_2_q <= issue_valid_2_d;
         issue_pc_1_q    <= bus.hd_data_1[63:32];
         issue_inst_1_q  <= bus.hd_data_1[31:0];
         issue_pc_2_q    <= bus.hd_data_2[63:32];
         issue_inst_2_q  <= bus.hd_data_2[31:0];
      end
   end

   assign bus.queue_ready = ((CW'(DEPTH) - count_q) >= CW'(2));
   assign bus.count       = count_q;
   assign bus.hd_data_1   = mem_q[rd_ptr_q];
   assign bus.hd_data_2   = mem_q[rd_ptr_p1];
   assign bus.hd_ok_1     = hd_ok_1;
   assign bus.hd_ok_2     = hd_ok_2;

   assign bus.issue_valid_1 = issue_valid_1_q;
`ifdef ISSUE_DUAL_EN
   assign bus.issue_valid_2 = issue_valid_2_q;
`else
   assign bus.issue_valid_2 = 1'b0 & issue_valid_2_q;
`endif
   assign bus.issue_pc_1   = issue_pc_1_q;
   assign bus.issue_inst_1 = issue_inst_1_q;
   assign bus.issue_pc_2   = issue_pc_2_q;
   assign bus.issue_inst_2 = issue_inst_2_q;
endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue (DEPTH=4): reset, RAW/$0, jump delay slot, full/wrap, stall/flush.
// Expectations follow ISSUE_DUAL_EN the same way the design does.
module tb_issue_queue;
   localparam int DEPTH   = 4;
   localparam int ENTRY_W = 64;

   logic clk;
   logic resetn;
   int   checks;
   int   failures;

   issue_queue_if #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) bus ();

   issue_queue #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [63:0] ent(input logic [31:0] pc);
      return {pc, pc ^ 32'hA5A5_0000};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push2(input logic [31:0] pa, input logic [31:0] pb);
      bus.push_en_1 = 1'b1;  bus.push_data_1 = ent(pa);
      bus.push_en_2 = 1'b1;  bus.push_data_2 = ent(pb);
   endtask

   task automatic push1(input logic [31:0] pa);
      bus.push_en_1 = 1'b1;  bus.push_data_1 = ent(pa);
      bus.push_en_2 = 1'b0;
   endtask

   task automatic push_off();
      bus.push_en_1 = 1'b0;
      bus.push_en_2 = 1'b0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      resetn = 1'b0;
      bus.flush = 1'b0;
      bus.issue_stall = 1'b0;
      bus.hd1_is_jmp = 1'b0;
      bus.hd1_is_ls = 1'b0;
      bus.hd1_w_reg_dst = 5'd0;
      bus.hd2_is_jmp = 1'b0;
      bus.hd2_rs = 5'd0;
      bus.hd2_rt = 5'd7;
      push2(32'h100, 32'h104);

      // Reset with a push pending: nothing may land.
      step();
      check("rst_count", 64'(bus.count), 64'd0);
      check("rst_v1", 64'(bus.issue_valid_1), 64'd0);
      check("rst_v2", 64'(bus.issue_valid_2), 64'd0);
      check("rst_pc1", 64'(bus.issue_pc_1), 64'd0);
      step();
      check("rst2_count", 64'(bus.count), 64'd0);
      check("rst2_ready", 64'(bus.queue_ready), 64'd1);
      check("rst2_v1", 64'(bus.issue_valid_1), 64'd0);
      resetn = 1'b1;
      step();
      check("push_count", 64'(bus.count), 64'd2);
      check("push_ok1", 64'(bus.hd_ok_1), 64'd1);
      check("push_ok2", 64'(bus.hd_ok_2), 64'd1);
      check("push_hd1", bus.hd_data_1, ent(32'h100));
      check("push_hd2", bus.hd_data_2, ent(32'h104));
      push_off();
      step();
`ifdef ISSUE_DUAL_EN
      check("ab_v1", 64'(bus.issue_valid_1), 64'd1);
      check("ab_v2", 64'(bus.issue_valid_2), 64'd1);
      check("ab_pc1", 64'(bus.issue_pc_1), 64'h100);
      check("ab_pc2", 64'(bus.issue_pc_2), 64'h104);
      check("ab_inst2", 64'(bus.issue_inst_2), 64'(ent(32'h104)) & 64'hFFFF_FFFF);
      check("ab_count", 64'(bus.count), 64'd0);
`else
      check("ab_v1", 64'(bus.issue_valid_1), 64'd1);
      check("ab_v2", 64'(bus.issue_valid_2), 64'd0);
      check("ab_pc1", 64'(bus.issue_pc_1), 64'h100);
      check("ab_count", 64'(bus.count), 64'd1);
      step();
      check("b_v1", 64'(bus.issue_valid_1), 64'd1);
      check("b_pc1", 64'(bus.issue_pc_1), 64'h104);
      check("b_count", 64'(bus.count), 64'd0);
`endif

      // RAW on r5: head issues alone.
      push2(32'h200, 32'h204);
      step();
      check("raw_fill", 64'(bus.count), 64'd2);
      push_off();
      bus.hd1_w_reg_dst = 5'd5;
      bus.hd2_rs = 5'd5;
      step();
      check("raw_v1", 64'(bus.issue_valid_1), 64'd1);
      check("raw_v2", 64'(bus.issue_valid_2), 64'd0);
      check("raw_pc1", 64'(bus.issue_pc_1), 64'h200);
      check("raw_count", 64'(bus.count), 64'd1);
      bus.hd1_w_reg_dst = 5'd0;
      bus.hd2_rs = 5'd0;
      step();
      check("raw_tail_pc1", 64'(bus.issue_pc_1), 64'h204);
      check("raw_tail_count", 64'(bus.count), 64'd0);

      // $0 destination never creates a dependency.
      push2(32'h300, 32'h304);
      step();
      push_off();
      step();
`ifdef ISSUE_DUAL_EN
      check("r0_v2", 64'(bus.issue_valid_2), 64'd1);
      check("r0_pc1", 64'(bus.issue_pc_1), 64'h300);
      check("r0_pc2", 64'(bus.issue_pc_2), 64'h304);
      check("r0_count", 64'(bus.count), 64'd0);
`else
      check("r0_v2", 64'(bus.issue_valid_2), 64'd0);
      check("r0_pc1", 64'(bus.issue_pc_1), 64'h300);
      check("r0_count", 64'(bus.count), 64'd1);
      step();
      check("r0_tail_pc1", 64'(bus.issue_pc_1), 64'h304);
      check("r0_tail_count", 64'(bus.count), 64'd0);
`endif

      // Jump waits for its delay slot.
      push1(32'h400);
      step();
      check("jmp_fill", 64'(bus.count), 64'd1);
      push_off();
      bus.hd1_is_jmp = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("jmp_wait_v1", 64'(bus.issue_valid_1), 64'd0);
         check("jmp_wait_count", 64'(bus.count), 64'd1);
      end
      push1(32'h404);
      step();
      check("jmp_slot_count", 64'(bus.count), 64'd2);
      check("jmp_slot_v1", 64'(bus.issue_valid_1), 64'd0);
      push_off();
      step();
`ifdef ISSUE_DUAL_EN
      check("jmp_v1", 64'(bus.issue_valid_1), 64'd1);
      check("jmp_v2", 64'(bus.issue_valid_2), 64'd1);
      check("jmp_pc1", 64'(bus.issue_pc_1), 64'h400);
      check("jmp_pc2", 64'(bus.issue_pc_2), 64'h404);
      check("jmp_count", 64'(bus.count), 64'd0);
      bus.hd1_is_jmp = 1'b0;
`else
      check("jmp_v1", 64'(bus.issue_valid_1), 64'd1);
      check("jmp_v2", 64'(bus.issue_valid_2), 64'd0);
      check("jmp_pc1", 64'(bus.issue_pc_1), 64'h400);
      check("jmp_count", 64'(bus.count), 64'd1);
      bus.hd1_is_jmp = 1'b0;
      step();
      check("ds_v1", 64'(bus.issue_valid_1), 64'd1);
      check("ds_pc1", 64'(bus.issue_pc_1), 64'h404);
      check("ds_count", 64'(bus.count), 64'd0);
`endif

      // Shift the pointers to 1 so the full queue straddles index 3 -> 0.
      push1(32'h500);
      step();
      push_off();
      step();
      check("x_pc1", 64'(bus.issue_pc_1), 64'h500);
      check("x_count", 64'(bus.count), 64'd0);
      bus.issue_stall = 1'b1;
      push2(32'h600, 32'h604);
      step();
      push2(32'h608, 32'h60C);
      step();
      check("full_count", 64'(bus.count), 64'd4);
      check("full_ready", 64'(bus.queue_ready), 64'd0);
      check("full_hold_pc1", 64'(bus.issue_pc_1), 64'h500);
      push1(32'h7FF);
      step();
      check("drop_count", 64'(bus.count), 64'd4);
      check("drop_hd1", bus.hd_data_1, ent(32'h600));
      bus.issue_stall = 1'b0;
      push2(32'h700, 32'h704);
      step();
`ifdef ISSUE_DUAL_EN
      check("fp_pc1", 64'(bus.issue_pc_1), 64'h600);
      check("fp_pc2", 64'(bus.issue_pc_2), 64'h604);
      check("fp_count", 64'(bus.count), 64'd4);
      check("wrap_hd1", bus.hd_data_1, ent(32'h608));
      check("wrap_hd2", bus.hd_data_2, ent(32'h60C));
      push_off();
      step();
      check("wrap_pc1", 64'(bus.issue_pc_1), 64'h608);
      check("wrap_pc2", 64'(bus.issue_pc_2), 64'h60C);
      check("wrap_count", 64'(bus.count), 64'd2);
      step();
      check("h_pc1", 64'(bus.issue_pc_1), 64'h700);
      check("h_pc2", 64'(bus.issue_pc_2), 64'h704);
      check("h_count", 64'(bus.count), 64'd0);
`else
      check("fp_pc1", 64'(bus.issue_pc_1), 64'h600);
      check("fp_count", 64'(bus.count), 64'd3);
      push_off();
      step();
      check("g1_pc1", 64'(bus.issue_pc_1), 64'h604);
      check("wrap_hd1", bus.hd_data_1, ent(32'h608));
      check("wrap_hd2", bus.hd_data_2, ent(32'h60C));
      step();
      check("g2_pc1", 64'(bus.issue_pc_1), 64'h608);
      step();
      check("g3_pc1", 64'(bus.issue_pc_1), 64'h60C);
      check("g3_count", 64'(bus.count), 64'd0);
`endif

      // Stall freezes the slots and the queue; flush then clears everything.
      push2(32'h800, 32'h804);
      step();
      push2(32'h808, 32'h80C);
      step();
      push_off();
      bus.issue_stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check("stall_v1", 64'(bus.issue_valid_1), 64'd1);
         check("stall_pc1", 64'(bus.issue_pc_1), 64'h800);
`ifdef ISSUE_DUAL_EN
         check("stall_v2", 64'(bus.issue_valid_2), 64'd1);
         check("stall_pc2", 64'(bus.issue_pc_2), 64'h804);
         check("stall_count", 64'(bus.count), 64'd2);
`else
         check("stall_count", 64'(bus.count), 64'd3);
`endif
      end
      bus.flush = 1'b1;
      push1(32'h900);
      step();
      check("flush_count", 64'(bus.count), 64'd0);
      check("flush_v1", 64'(bus.issue_valid_1), 64'd0);
      check("flush_v2", 64'(bus.issue_valid_2), 64'd0);
      check("flush_ok1", 64'(bus.hd_ok_1), 64'd0);
      bus.flush = 1'b0;
      bus.issue_stall = 1'b0;
      push_off();
      step();
      check("post_flush_count", 64'(bus.count), 64'd0);
      check("post_flush_v1", 64'(bus.issue_valid_1), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
